// File: rtl/hue_fade_if.sv
// Hue fade sequencer bus: fade control inputs from the PWM side and the
// committed duty values, phase and reload strobe back to the PWM stage.
interface hue_fade_if #(
    parameter int unsigned PWM_INTERVAL = 1200
);
    localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);

    logic          enable;
    logic          period_start;
    logic [DW-1:0] duty_r;
    logic [DW-1:0] duty_g;
    logic [DW-1:0] duty_b;
    logic [2:0]    phase;
    logic          duty_update;

    modport master (
        output enable,
        output period_start,
        input  duty_r,
        input  duty_g,
        input  duty_b,
        input  phase,
        input  duty_update
    );

    modport slave (
        input  enable,
        input  period_start,
        output duty_r,
        output duty_g,
        output duty_b,
        output phase,
        output duty_update
    );
endinterface

// File: rtl/hue_fade_sequencer.sv
// Hue fade sequencer: walks a six-phase hue wheel and produces R/G/B PWM duty
// values. A free-running tick advances a ramp; the (phase, ramp) pair is
// mapped to shadow duties, which are committed to the outputs only when the
// PWM stage signals the start of a new period.
module hue_fade_sequencer #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEP_SIZE    = 12,
    parameter int unsigned TICK_CYCLES  = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    hue_fade_if.slave  bus
);
    localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
    localparam logic [DW:0]   FULL_W    = (DW + 1)'(PWM_INTERVAL);
    localparam logic [DW:0]   STEP_W    = (DW + 1)'(STEP_SIZE);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4,
        PH5 = 3'd5
    } phase_e;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [DW-1:0] ramp_q, ramp_d;
    logic [DW:0]   ramp_sum;
    phase_e        phase_q, phase_d;
    phase_e        sh_phase_q;
    logic [DW-1:0] dn;
    logic [DW-1:0] sh_r_q, sh_g_q, sh_b_q;
    logic [DW-1:0] sh_r_d, sh_g_d, sh_b_d;
    logic [DW-1:0] duty_r_q, duty_g_q, duty_b_q;
    logic          duty_update_q;

    // Tick generator: counts while enabled, holds (not clears) while disabled.
    always_comb begin
        tick       = bus.enable && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (bus.enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Ramp/phase next state: step the ramp per tick, roll to the next phase at full scale.
    always_comb begin
        ramp_sum = {1'b0, ramp_q} + STEP_W;
        ramp_d   = ramp_q;
        phase_d  = phase_q;
        if (tick) begin
            if (ramp_sum >= FULL_W) begin
                ramp_d = '0;
                case (phase_q)
                    PH0:     phase_d = PH1;
                    PH1:     phase_d = PH2;
                    PH2:     phase_d = PH3;
                    PH3:     phase_d = PH4;
                    PH4:     phase_d = PH5;
                    default: phase_d = PH0;
                endcase
            end else begin
                ramp_d = ramp_sum[DW-1:0];
            end
        end
    end

    // Hue wheel mapping: one channel rises or falls while the others sit at 0 or FULL.
    always_comb begin
        dn     = FULL - ramp_q;
        sh_r_d = FULL;
        sh_g_d = '0;
        sh_b_d = '0;
        case (phase_q)
            PH0: begin sh_r_d = FULL;   sh_g_d = ramp_q; sh_b_d = '0;     end
            PH1: begin sh_r_d = dn;     sh_g_d = FULL;   sh_b_d = '0;     end
            PH2: begin sh_r_d = '0;     sh_g_d = FULL;   sh_b_d = ramp_q; end
            PH3: begin sh_r_d = '0;     sh_g_d = dn;     sh_b_d = FULL;   end
            PH4: begin sh_r_d = ramp_q; sh_g_d = '0;     sh_b_d = FULL;   end
            PH5: begin sh_r_d = FULL;   sh_g_d = '0;     sh_b_d = dn;     end
            default: begin sh_r_d = FULL; sh_g_d = '0;   sh_b_d = '0;     end
        endcase
    end

    // State, shadow and commit registers; commit reads the shadow as it stood before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            ramp_q        <= '0;
            phase_q       <= PH0;
            sh_phase_q    <= PH0;
            sh_r_q        <= FULL;
            sh_g_q        <= '0;
            sh_b_q        <= '0;
            duty_r_q      <= FULL;
            duty_g_q      <= '0;
            duty_b_q      <= '0;
            duty_update_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            ramp_q        <= ramp_d;
            phase_q       <= phase_d;
            sh_phase_q    <= phase_q;
            sh_r_q        <= sh_r_d;
            sh_g_q        <= sh_g_d;
            sh_b_q        <= sh_b_d;
            duty_update_q <= bus.period_start;
            if (bus.period_start) begin
                duty_r_q <= sh_r_q;
                duty_g_q <= sh_g_q;
                duty_b_q <= sh_b_q;
            end
        end
    end

    assign bus.duty_r      = duty_r_q;
    assign bus.duty_g      = duty_g_q;
    assign bus.duty_b      = duty_b_q;
    assign bus.phase       = sh_phase_q;
    assign bus.duty_update = duty_update_q;
endmodule

// File: tb/tb_hue_fade_sequencer.sv
// Directed testbench for hue_fade_sequencer with PWM_INTERVAL=12, STEP_SIZE=4,
// TICK_CYCLES=3: 3 ticks per phase, 18 wheel positions per rainbow.
module tb_hue_fade_sequencer;
    localparam int unsigned PWM   = 12;
    localparam int unsigned STEP  = 4;
    localparam int unsigned TICKS = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hue_fade_if #(.PWM_INTERVAL(PWM)) bus ();

    hue_fade_sequencer #(
        .PWM_INTERVAL (PWM),
        .STEP_SIZE    (STEP),
        .TICK_CYCLES  (TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Hand-computed wheel: position t = ticks taken; phase = t/3, ramp = 4*(t%3).
    int wheel_ph [18] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5};
    int wheel_r  [18] = '{12, 12, 12, 12, 8, 4, 0, 0, 0, 0, 0, 0, 0, 4, 8, 12, 12, 12};
    int wheel_g  [18] = '{0, 4, 8, 12, 12, 12, 12, 12, 12, 12, 8, 4, 0, 0, 0, 0, 0, 0};
    int wheel_b  [18] = '{0, 0, 0, 0, 0, 0, 0, 4, 8, 12, 12, 12, 12, 12, 12, 12, 8, 4};

    int n_checks = 0;
    int n_errors = 0;

    // Expected-state tracking: enabled edges so far, wheel position of shadow and outputs.
    int en_cnt = 0;
    int sh_t   = 0;
    int out_t  = 0;
    int exp_upd = 0;
    int prev_r = 12, prev_g = 0, prev_b = 0;
    bit cont_chk = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // One clock: drive inputs, advance the expected state, compare all outputs.
    task automatic step(input logic rst, input logic en, input logic ps, input string tag);
        int r, g, b;
        rst_n            = rst;
        bus.enable       = en;
        bus.period_start = ps;
        @(posedge clk);
        #1;
        if (!rst) begin
            en_cnt  = 0;
            sh_t    = 0;
            out_t   = 0;
            exp_upd = 0;
        end else begin
            if (ps) out_t = sh_t;
            sh_t = (en_cnt / int'(TICKS)) % 18;
            if (en) en_cnt++;
            exp_upd = int'(ps);
        end
        r = int'(bus.duty_r);
        g = int'(bus.duty_g);
        b = int'(bus.duty_b);
        check({tag, ".duty_r"}, r, wheel_r[out_t]);
        check({tag, ".duty_g"}, g, wheel_g[out_t]);
        check({tag, ".duty_b"}, b, wheel_b[out_t]);
        check({tag, ".phase"}, int'(bus.phase), wheel_ph[sh_t]);
        check({tag, ".duty_update"}, int'(bus.duty_update), exp_upd);
        if (cont_chk) begin
            check({tag, ".in_range"}, int'(r <= 12 && g <= 12 && b <= 12), 1);
            check({tag, ".step_le_4"},
                  int'(absdiff(r, prev_r) <= 4 && absdiff(g, prev_g) <= 4 && absdiff(b, prev_b) <= 4), 1);
        end
        prev_r = r;
        prev_g = g;
        prev_b = b;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.enable       = 1'b1;
        bus.period_start = 1'b1;

        // Reset held two cycles, then a full wheel plus wrap with a commit every cycle.
        step(1'b0, 1'b1, 1'b1, "reset");
        step(1'b0, 1'b1, 1'b1, "reset");
        cont_chk = 1'b1;
        for (int i = 0; i < 57; i++) step(1'b1, 1'b1, 1'b1, "wheel");
        cont_chk = 1'b0;

        // Commit only every 10 cycles while the shadow keeps advancing.
        step(1'b0, 1'b1, 1'b1, "reset2");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, (i % 10 == 0), "gate");

        // Enable dropped for 20 cycles in phase 2 with tick_cnt=1, then resumed.
        step(1'b0, 1'b1, 1'b1, "reset3");
        for (int i = 0; i < 19; i++) step(1'b1, 1'b1, 1'b1, "pre_hold");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, "hold");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, "resume");

        // period_start only on tick cycles: each commit takes the pre-tick shadow.
        step(1'b0, 1'b1, 1'b1, "reset4");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, (i % 3 == 2), "collide");

        // Run into phase 4, then reset mid-fade with period_start asserted.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1, "to_ph4");
        check("mid_phase4", int'(bus.phase), 4);
        step(1'b0, 1'b1, 1'b1, "midrst");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
